// File: rtl/dac_bus_rx.sv
// Receiver for the dual-channel parallel DAC write bus: synchronises the bus into
// sys_clk, decodes write/load strobes into double-buffered registers and flags misuse.
module dac_bus_rx #(
  parameter int DW          = 12,
  parameter int SYNC_STAGES = 2,
  parameter int PW          = 24
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  input  logic          c_clk,
  input  logic          CS,
  input  logic          R_W,
  input  logic          LOADDAC,
  input  logic [DW-1:0] Data_r1,
  input  logic [DW-1:0] Data_r2,
  input  logic          clr_flags,
  output logic [DW-1:0] dac_out1,
  output logic [DW-1:0] dac_out2,
  output logic          load_valid,
  output logic [15:0]   wr_cnt,
  output logic [PW-1:0] load_period,
  output logic          overrun,
  output logic          stale_load,
  output logic          rd_err
);

  localparam int N = SYNC_STAGES;
  localparam logic [PW-1:0] PMAX = '1;
  localparam logic [PW-1:0] PONE = 1;

  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [N-1:0]    r_clk_s, r_cs_s, r_rw_s, r_ld_s;
  logic [DW-1:0]   r_d1_s [N];
  logic [DW-1:0]   r_d2_s [N];
  logic            r_clk_d, r_ld_d;
  logic            w_c_rise, w_wr, w_rd, w_ld;
  logic            r_wr_ev, r_rd_ev, r_ld_ev;
  logic [DW-1:0]   r_wdat1, r_wdat2;
  logic [DW-1:0]   r_in1, r_in2, r_out1, r_out2;
  logic            r_lv;
  logic [15:0]     r_wr_cnt;
  logic [PW-1:0]   r_per, r_lp;
  logic            r_ovr, r_stale, r_rderr;
  logic            w_set_ovr, w_set_stale;

  // Reset levels match an idle bus so releasing reset never fakes an edge.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_s <= '0;
      r_cs_s  <= '1;
      r_rw_s  <= '1;
      r_ld_s  <= '1;
      r_clk_d <= 1'b0;
      r_ld_d  <= 1'b1;
      for (int i = 0; i < N; i++) begin
        r_d1_s[i] <= '0;
        r_d2_s[i] <= '0;
      end
    end else begin
      r_clk_s   <= {r_clk_s[N-2:0], c_clk};
      r_cs_s    <= {r_cs_s[N-2:0], CS};
      r_rw_s    <= {r_rw_s[N-2:0], R_W};
      r_ld_s    <= {r_ld_s[N-2:0], LOADDAC};
      r_clk_d   <= r_clk_s[N-1];
      r_ld_d    <= r_ld_s[N-1];
      r_d1_s[0] <= Data_r1;
      r_d2_s[0] <= Data_r2;
      for (int i = 1; i < N; i++) begin
        r_d1_s[i] <= r_d1_s[i-1];
        r_d2_s[i] <= r_d2_s[i-1];
      end
    end
  end

  assign w_c_rise = r_clk_s[N-1] & ~r_clk_d;
  assign w_wr     = w_c_rise & ~r_cs_s[N-1] & ~r_rw_s[N-1];
  assign w_rd     = w_c_rise & ~r_cs_s[N-1] &  r_rw_s[N-1];
  assign w_ld     = ~r_ld_s[N-1] & r_ld_d;

  // Decoded events are registered together with their data, keeping them aligned.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ev <= 1'b0;
      r_rd_ev <= 1'b0;
      r_ld_ev <= 1'b0;
      r_wdat1 <= '0;
      r_wdat2 <= '0;
    end else begin
      r_wr_ev <= w_wr;
      r_rd_ev <= w_rd;
      r_ld_ev <= w_ld;
      r_wdat1 <= r_d1_s[N-1];
      r_wdat2 <= r_d2_s[N-1];
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_ld_ev)      w_state_nxt = IDLE;
    else if (r_wr_ev) w_state_nxt = PENDING;
  end

  always_comb begin
    w_set_ovr   = 1'b0;
    w_set_stale = 1'b0;
    case (r_state)
      IDLE:    w_set_stale = r_ld_ev & ~r_wr_ev;
      PENDING: w_set_ovr   = r_wr_ev & ~r_ld_ev;
      default: ;
    endcase
  end

  // A write coinciding with a load bypasses the input register straight to the output.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in1    <= '0;
      r_in2    <= '0;
      r_out1   <= '0;
      r_out2   <= '0;
      r_lv     <= 1'b0;
      r_wr_cnt <= '0;
      r_per    <= '0;
      r_lp     <= '0;
      r_ovr    <= 1'b0;
      r_stale  <= 1'b0;
      r_rderr  <= 1'b0;
    end else begin
      if (r_wr_ev) begin
        r_in1 <= r_wdat1;
        r_in2 <= r_wdat2;
      end
      if (r_ld_ev) begin
        r_out1 <= r_wr_ev ? r_wdat1 : r_in1;
        r_out2 <= r_wr_ev ? r_wdat2 : r_in2;
        r_lp   <= (r_per == PMAX) ? PMAX : r_per + PONE;
      end
      r_lv     <= r_ld_ev;
      r_wr_cnt <= (clr_flags ? 16'd0 : r_wr_cnt) + {15'd0, r_wr_ev};
      if (r_ld_ev || clr_flags) r_per <= '0;
      else if (r_per != PMAX)   r_per <= r_per + PONE;
      r_ovr   <= (r_ovr   & ~clr_flags) | w_set_ovr;
      r_stale <= (r_stale & ~clr_flags) | w_set_stale;
      r_rderr <= (r_rderr & ~clr_flags) | r_rd_ev;
    end
  end

  assign dac_out1    = r_out1;
  assign dac_out2    = r_out2;
  assign load_valid  = r_lv;
  assign wr_cnt      = r_wr_cnt;
  assign load_period = r_lp;
  assign overrun     = r_ovr;
  assign stale_load  = r_stale;
  assign rd_err      = r_rderr;

endmodule

// File: tb/tb_dac_bus_rx.sv
// Bench for dac_bus_rx: a bus-level model that sees each bus sample three cycles late,
// checked every cycle, plus directed scenarios with literal expectations.
module tb_dac_bus_rx;

  localparam int DW  = 12;
  localparam int PW  = 24;
  localparam longint PMAX = (64'd1 << PW) - 1;

  typedef struct packed {
    logic          c;
    logic          cs;
    logic          rw;
    logic          ld;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
  } bus_t;

  logic          sys_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          c_clk = 1'b0;
  logic          CS = 1'b1;
  logic          R_W = 1'b1;
  logic          LOADDAC = 1'b1;
  logic [DW-1:0] Data_r1 = '0;
  logic [DW-1:0] Data_r2 = '0;
  logic          clr_flags = 1'b0;
  logic [DW-1:0] dac_out1, dac_out2;
  logic          load_valid;
  logic [15:0]   wr_cnt;
  logic [PW-1:0] load_period;
  logic          overrun, stale_load, rd_err;

  int n_checks = 0;
  int n_errors = 0;
  int lv_count = 0;
  int lv0;

  dac_bus_rx #(.DW(DW), .SYNC_STAGES(2), .PW(PW)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .c_clk(c_clk), .CS(CS), .R_W(R_W),
    .LOADDAC(LOADDAC), .Data_r1(Data_r1), .Data_r2(Data_r2), .clr_flags(clr_flags),
    .dac_out1(dac_out1), .dac_out2(dac_out2), .load_valid(load_valid), .wr_cnt(wr_cnt),
    .load_period(load_period), .overrun(overrun), .stale_load(stale_load), .rd_err(rd_err)
  );

  // clock / watchdog
  always #5 sys_clk = ~sys_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: bus effects appear three sys_clk edges after the bus is first sampled
  bus_t          hist[$];
  logic          m_pend;
  logic [DW-1:0] m_in1, m_in2, m_out1, m_out2;
  logic          m_lv, m_ovr, m_stale, m_rderr;
  logic [15:0]   m_wrcnt;
  logic [PW-1:0] m_lp;
  longint        m_n, m_mark;

  task automatic m_reset();
    bus_t idle;
    idle = '{c: 1'b0, cs: 1'b1, rw: 1'b1, ld: 1'b1, d1: '0, d2: '0};
    hist.delete();
    for (int i = 0; i < 5; i++) hist.push_back(idle);
    m_pend = 1'b0;
    m_in1 = '0; m_in2 = '0; m_out1 = '0; m_out2 = '0;
    m_lv = 1'b0; m_ovr = 1'b0; m_stale = 1'b0; m_rderr = 1'b0;
    m_wrcnt = '0; m_lp = '0; m_n = 0; m_mark = 0;
  endtask

  initial begin
    bus_t s, cur, prv;
    logic rise, wr, rd, ld, set_ovr, set_stale;
    longint gap;
    m_reset();
    forever begin
      @(posedge sys_clk or negedge rst_n);
      if (!rst_n) begin
        m_reset();
      end else begin
        s = '{c: c_clk, cs: CS, rw: R_W, ld: LOADDAC, d1: Data_r1, d2: Data_r2};
        hist.push_back(s);
        if (hist.size() > 8) void'(hist.pop_front());
        cur = hist[hist.size()-4];
        prv = hist[hist.size()-5];
        rise = cur.c && !prv.c;
        wr = rise && !cur.cs && !cur.rw;
        rd = rise && !cur.cs && cur.rw;
        ld = !cur.ld && prv.ld;
        m_n++;
        set_ovr   = wr && m_pend && !ld;
        set_stale = ld && !m_pend && !wr;
        if (clr_flags) m_wrcnt = '0;
        if (wr) begin
          m_in1 = cur.d1;
          m_in2 = cur.d2;
          m_wrcnt = m_wrcnt + 16'd1;
        end
        m_lv = ld;
        if (ld) begin
          m_out1 = m_in1;
          m_out2 = m_in2;
          gap = m_n - m_mark;
          m_lp = (gap > PMAX) ? PW'(PMAX) : PW'(gap);
        end
        if (ld || clr_flags) m_mark = m_n;
        m_pend  = ld ? 1'b0 : (wr ? 1'b1 : m_pend);
        m_ovr   = (m_ovr && !clr_flags) || set_ovr;
        m_stale = (m_stale && !clr_flags) || set_stale;
        m_rderr = (m_rderr && !clr_flags) || rd;
      end
    end
  end

  // scoreboard: every cycle out of reset
  initial begin
    forever begin
      @(negedge sys_clk);
      if (rst_n) begin
        chk("m_dac_out1", 32'(dac_out1), 32'(m_out1));
        chk("m_dac_out2", 32'(dac_out2), 32'(m_out2));
        chk("m_load_valid", 32'(load_valid), 32'(m_lv));
        chk("m_wr_cnt", 32'(wr_cnt), 32'(m_wrcnt));
        chk("m_load_period", 32'(load_period), 32'(m_lp));
        chk("m_overrun", 32'(overrun), 32'(m_ovr));
        chk("m_stale_load", 32'(stale_load), 32'(m_stale));
        chk("m_rd_err", 32'(rd_err), 32'(m_rderr));
        if (load_valid) lv_count++;
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic c_pulse();
    c_clk = 1'b1; tick(3);
    c_clk = 1'b0; tick(2);
  endtask

  task automatic bus_write(input logic [DW-1:0] d1, input logic [DW-1:0] d2);
    CS = 1'b0; R_W = 1'b0; Data_r1 = d1; Data_r2 = d2; tick(2);
    c_pulse();
    CS = 1'b1; R_W = 1'b1; tick(1);
  endtask

  task automatic bus_read(input logic [DW-1:0] d1);
    CS = 1'b0; R_W = 1'b1; Data_r1 = d1; tick(2);
    c_pulse();
    CS = 1'b1; tick(1);
  endtask

  task automatic bus_load();
    LOADDAC = 1'b0; tick(3);
    LOADDAC = 1'b1; tick(2);
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1; tick(1);
    clr_flags = 1'b0; tick(2);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dac_out1"}, 32'(dac_out1), 32'h0);
    chk({tag, "_dac_out2"}, 32'(dac_out2), 32'h0);
    chk({tag, "_load_valid"}, 32'(load_valid), 32'h0);
    chk({tag, "_wr_cnt"}, 32'(wr_cnt), 32'h0);
    chk({tag, "_load_period"}, 32'(load_period), 32'h0);
    chk({tag, "_overrun"}, 32'(overrun), 32'h0);
    chk({tag, "_stale_load"}, 32'(stale_load), 32'h0);
    chk({tag, "_rd_err"}, 32'(rd_err), 32'h0);
  endtask

  initial begin
    // reset state
    tick(3);
    chk_all_zero("rst");
    rst_n = 1'b1;
    tick(4);

    // single write then load
    lv0 = lv_count;
    bus_write(12'h5A5, 12'h123);
    bus_load();
    tick(6);
    chk("t1_dac_out1", 32'(dac_out1), 32'h5A5);
    chk("t1_dac_out2", 32'(dac_out2), 32'h123);
    chk("t1_wr_cnt", 32'(wr_cnt), 32'h1);
    chk("t1_lv_pulses", 32'(lv_count - lv0), 32'h1);
    chk("t1_overrun", 32'(overrun), 32'h0);
    chk("t1_stale", 32'(stale_load), 32'h0);
    chk("t1_rd_err", 32'(rd_err), 32'h0);

    // two writes before a load, then clear
    bus_write(12'h100, 12'h000);
    bus_write(12'h200, 12'h000);
    bus_load();
    tick(5);
    chk("t2_overrun", 32'(overrun), 32'h1);
    chk("t2_dac_out1", 32'(dac_out1), 32'h200);
    chk("t2_wr_cnt", 32'(wr_cnt), 32'h3);
    pulse_clr();
    chk("t2_overrun_clr", 32'(overrun), 32'h0);
    chk("t2_wr_cnt_clr", 32'(wr_cnt), 32'h0);
    chk("t2_dac_out1_kept", 32'(dac_out1), 32'h200);

    // load with nothing written since reset; first period counts from reset
    rst_n = 1'b0;
    tick(2);
    chk_all_zero("rst2");
    rst_n = 1'b1;
    lv0 = lv_count;
    bus_load();
    tick(6);
    chk("t3_stale", 32'(stale_load), 32'h1);
    chk("t3_dac_out1", 32'(dac_out1), 32'h0);
    chk("t3_dac_out2", 32'(dac_out2), 32'h0);
    chk("t3_lv_pulses", 32'(lv_count - lv0), 32'h1);
    chk("t3_load_period", 32'(load_period), 32'd4);

    // read cycle and deselected cycle leave the input registers alone
    bus_read(12'hFFF);
    tick(4);
    chk("t4_rd_err", 32'(rd_err), 32'h1);
    chk("t4_wr_cnt", 32'(wr_cnt), 32'h0);
    bus_load();
    tick(5);
    chk("t4_dac_out1", 32'(dac_out1), 32'h0);
    CS = 1'b1; R_W = 1'b0; Data_r1 = 12'hABC; tick(2);
    c_pulse();
    R_W = 1'b1; tick(4);
    chk("t4_cs_wr_cnt", 32'(wr_cnt), 32'h0);
    bus_load();
    tick(5);
    chk("t4_cs_dac_out1", 32'(dac_out1), 32'h0);

    // write edge and load edge sampled together
    pulse_clr();
    CS = 1'b0; R_W = 1'b0; Data_r1 = 12'h7FF; Data_r2 = 12'h456; tick(2);
    c_clk = 1'b1; LOADDAC = 1'b0; tick(3);
    c_clk = 1'b0; LOADDAC = 1'b1; tick(2);
    CS = 1'b1; R_W = 1'b1; tick(5);
    chk("t5_dac_out1", 32'(dac_out1), 32'h7FF);
    chk("t5_dac_out2", 32'(dac_out2), 32'h456);
    chk("t5_overrun", 32'(overrun), 32'h0);
    chk("t5_stale", 32'(stale_load), 32'h0);
    chk("t5_wr_cnt", 32'(wr_cnt), 32'h1);
    bus_load();
    tick(5);
    chk("t5_idle_after", 32'(stale_load), 32'h1);

    // loads exactly 1000 cycles apart
    pulse_clr();
    lv0 = lv_count;
    LOADDAC = 1'b0; tick(3);
    LOADDAC = 1'b1; tick(997);
    LOADDAC = 1'b0; tick(3);
    LOADDAC = 1'b1; tick(5);
    chk("t6_load_period", 32'(load_period), 32'd1000);
    chk("t6_lv_pulses", 32'(lv_count - lv0), 32'h2);

    // reset between write edge and load
    CS = 1'b0; R_W = 1'b0; Data_r1 = 12'h3C3; Data_r2 = 12'h0F0; tick(1);
    c_clk = 1'b1; tick(2);
    rst_n = 1'b0;
    tick(1);
    chk_all_zero("t7_in_rst");
    c_clk = 1'b0; CS = 1'b1; R_W = 1'b1; LOADDAC = 1'b1;
    tick(3);
    rst_n = 1'b1;
    lv0 = lv_count;
    tick(20);
    chk("t7_lv_pulses", 32'(lv_count - lv0), 32'h0);
    chk_all_zero("t7_after");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
